gb_host_bridge: RTL and testbench
=================================

Name: gb_host_bridge

Overview:
- Host-side master that feeds the ghostbus: converts a byte-serial command stream (valid/ready) into single-cycle ghostbus write and read-strobe cycles.
- Returns read data as a byte stream.
- Sits directly upstream of the ghostbus decode tree. Drives gb_addr/gb_wdata/gb_wen/gb_rstb and consumes gb_rdata.
- Byte side attaches to a UART/FIFO or a testbench.

Parameters:
- GB_AW, 24, ghostbus address width; must be a multiple of 8.
- GB_DW, 32, ghostbus data width; must be a multiple of 8.
- RD_LAT, 2, cycles from the gb_rstb-asserted cycle to the gb_rdata sample cycle; range 1..15.
- TO_CYCLES, 1000, inter-byte timeout; used only with the optional feature.

Ports:
- gb_clk  in  1  ghostbus clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  command-stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  bridge accepts the byte this cycle.
- out_data  out  8  response byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- gb_addr  out  GB_AW  ghostbus address.
- gb_wdata  out  GB_DW  ghostbus write data.
- gb_rdata  in  GB_DW  ghostbus read data.
- gb_wen  out  1  one-cycle write strobe.
- gb_rstb  out  1  one-cycle read strobe.
- busy  out  1  high whenever the state is not IDLE.
- bad_cmd_cnt  out  8  count of rejected command bytes; saturates at 255.

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous, active-high, named rst; the clock is gb_clk. While rst=1 at a gb_clk edge, all of the following are 0 on the next cycle:
  - gb_addr, gb_wdata, gb_wen, gb_rstb, out_valid, out_data, busy, bad_cmd_cnt
  - all byte counters
  - state returns to IDLE
- Reset mid-packet discards the partial packet and any pending response. No strobe is issued.
- Packet format, all multi-byte fields MSB first:
  - Write: cmd 0x01, then GB_AW/8 address bytes, then GB_DW/8 data bytes.
  - Read: cmd 0x02, then GB_AW/8 address bytes.
- A byte transfers when in_valid & in_ready at the clock edge.
- States and transitions:
  - IDLE (in_ready=1):
    - 0x01 -> ADDR (write).
    - 0x02 -> ADDR (read).
    - Any other byte is consumed, bad_cmd_cnt increments (saturating), state stays IDLE.
  - ADDR (in_ready=1): shift each byte into the address shadow register. After GB_AW/8 bytes: write -> DATA, read -> RSTB.
  - DATA (in_ready=1): shift bytes into the wdata shadow. After the last byte -> WSTB.
  - WSTB (in_ready=0):
    - gb_addr/gb_wdata load from the shadows on entry.
    - gb_wen=1 for exactly this one cycle, with gb_addr/gb_wdata already stable in the same cycle.
    - -> IDLE. Writes produce no response.
  - RSTB (in_ready=0):
    - gb_addr loads on entry.
    - gb_rstb=1 for exactly this one cycle.
    - -> RWAIT.
  - RWAIT: count RD_LAT cycles from the RSTB cycle. Latch gb_rdata in the cycle exactly RD_LAT after RSTB, then -> RESP.
  - RESP (in_ready=0): emit GB_DW/8 bytes MSB first.
    - out_valid=1, out_data held stable while out_valid & ~out_ready.
    - Advance one byte per accepted transfer.
    - After the last accepted byte, out_valid=0 in the next cycle -> IDLE.
- gb_addr and gb_wdata hold their last driven values between transactions. Shadow shifting never disturbs them.
- gb_wen and gb_rstb are never high in the same cycle, and never high outside WSTB/RSTB.
- Minimum command throughput: write = 1+GB_AW/8+GB_DW/8+1 cycles; read = 1+GB_AW/8+1+RD_LAT+GB_DW/8 cycles with back-to-back valid/ready.
- The bridge accepts no new command until the response drains (single outstanding transaction).

Optional Feature:
- Macro: GB_BRIDGE_TIMEOUT_EN.
- Defined:
  - In ADDR or DATA, a counter increments on every cycle with no accepted byte and resets on each accepted byte.
  - When it reaches TO_CYCLES, the partial packet is discarded, bad_cmd_cnt increments (saturating), state -> IDLE.
  - No strobe is issued and gb_addr/gb_wdata are unchanged.
- Undefined: the counter logic is absent; the bridge waits indefinitely mid-packet.

Test Plan:
- Write: stream 01 00 00 10 DE AD BE EF with in_valid always high -> exactly one gb_wen cycle with gb_addr=0x000010, gb_wdata=0xDEADBEEF; no out_valid; gb_addr holds 0x000010 afterwards.
- Read, RD_LAT=2: stream 02 00 00 10, gb_rdata model returns 0x12345678 two cycles after gb_rstb -> one gb_rstb cycle with gb_addr=0x000010, then out bytes 12 34 56 78 in order.
- Response backpressure: same read with out_ready toggled 1,0,0,1,0,1,1 -> out_data stable while stalled; exactly 4 transfers; in_ready=0 until the last one is accepted.
- Bad commands: stream 7F 00 02 00 00 04 -> bad_cmd_cnt=2; subsequent read of address 0x000004 completes normally. Stream 300 bad bytes -> bad_cmd_cnt=255.
- Reset mid-packet: stream 01 00 00, assert rst one cycle, then stream 02 00 00 20 -> no gb_wen ever; all outputs 0 after reset; read of 0x000020 proceeds.
- GB_BRIDGE_TIMEOUT_EN, TO_CYCLES=1000: stream 01 00, idle 1000 cycles -> state IDLE, bad_cmd_cnt=1, no gb_wen. Without the macro the same stimulus leaves busy=1.

Source files
------------

// File: rtl/gb_host_bridge.sv
// Byte-serial command bridge that issues single-cycle ghostbus writes and read strobes.
// Define GB_BRIDGE_TIMEOUT_EN to abandon packets that stall mid-stream for TO_CYCLES cycles.
module gb_host_bridge #(
    parameter int unsigned GB_AW     = 24,
    parameter int unsigned GB_DW     = 32,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned TO_CYCLES = 1000
) (
    input  logic             gb_clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [GB_AW-1:0] gb_addr,
    output logic [GB_DW-1:0] gb_wdata,
    input  logic [GB_DW-1:0] gb_rdata,
    output logic             gb_wen,
    output logic             gb_rstb,
    output logic             busy,
    output logic [7:0]       bad_cmd_cnt
);

    localparam int unsigned AB   = GB_AW / 8;
    localparam int unsigned DB   = GB_DW / 8;
    localparam int unsigned MAXB = (AB > DB) ? AB : DB;
    localparam int unsigned BCW  = $clog2(MAXB + 1);
    localparam int unsigned LCW  = $clog2(RD_LAT + 1);

    localparam logic [BCW-1:0] A_LAST   = BCW'(AB - 1);
    localparam logic [BCW-1:0] D_LAST   = BCW'(DB - 1);
    localparam logic [LCW-1:0] LAT_LAST = LCW'(RD_LAT);

    if ((GB_AW % 8 != 0) || (GB_DW % 8 != 0) || (GB_AW == 0) || (GB_DW == 0) ||
        (RD_LAT < 1) || (RD_LAT > 15) || (TO_CYCLES < 1)) begin : g_param_check
        $error("gb_host_bridge: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StWstb,
        StRstb,
        StRwait,
        StResp
    } state_e;

    state_e           state;
    logic             is_write;
    logic [BCW-1:0]   byte_cnt;
    logic [LCW-1:0]   lat_cnt;
    logic [GB_AW-1:0] addr_sh;
    logic [GB_DW-1:0] wdata_sh;
    logic [GB_DW-1:0] resp_sh;
    logic [GB_AW-1:0] addr_nxt;
    logic [GB_DW-1:0] wdata_nxt;
    logic             accept;

`ifdef GB_BRIDGE_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TO_CYCLES + 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TO_CYCLES - 1);
    logic [TCW-1:0] to_cnt;
`endif

    assign in_ready = (state == StIdle) || (state == StAddr) || (state == StData);
    assign busy     = (state != StIdle);
    assign accept   = in_valid && in_ready;
    assign out_data = resp_sh[GB_DW-1 -: 8];

    // Bytes land at their MSB-first position, so the shadow plus the current byte is the full word.
    always_comb begin
        addr_nxt  = addr_sh;
        wdata_nxt = wdata_sh;
        for (int unsigned i = 0; i < AB; i++) begin
            if (byte_cnt == BCW'(AB - 1 - i)) begin
                addr_nxt[8*i +: 8] = in_data;
            end
        end
        for (int unsigned i = 0; i < DB; i++) begin
            if (byte_cnt == BCW'(DB - 1 - i)) begin
                wdata_nxt[8*i +: 8] = in_data;
            end
        end
    end

    always_ff @(posedge gb_clk) begin
        if (rst) begin
            state       <= StIdle;
            is_write    <= 1'b0;
            byte_cnt    <= '0;
            lat_cnt     <= '0;
            addr_sh     <= '0;
            wdata_sh    <= '0;
            resp_sh     <= '0;
            gb_addr     <= '0;
            gb_wdata    <= '0;
            gb_wen      <= 1'b0;
            gb_rstb     <= 1'b0;
            out_valid   <= 1'b0;
            bad_cmd_cnt <= '0;
`ifdef GB_BRIDGE_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            gb_wen  <= 1'b0;
            gb_rstb <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (accept) begin
                        byte_cnt <= '0;
                        if (in_data == 8'h01) begin
                            is_write <= 1'b1;
                            state    <= StAddr;
                        end else if (in_data == 8'h02) begin
                            is_write <= 1'b0;
                            state    <= StAddr;
                        end else if (bad_cmd_cnt != 8'hFF) begin
                            bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
                        end
                    end
                end
                StAddr: begin
                    if (accept) begin
                        addr_sh <= addr_nxt;
                        if (byte_cnt == A_LAST) begin
                            byte_cnt <= '0;
                            if (is_write) begin
                                state <= StData;
                            end else begin
                                gb_addr <= addr_nxt;
                                gb_rstb <= 1'b1;
                                state   <= StRstb;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        wdata_sh <= wdata_nxt;
                        if (byte_cnt == D_LAST) begin
                            byte_cnt <= '0;
                            gb_addr  <= addr_sh;
                            gb_wdata <= wdata_nxt;
                            gb_wen   <= 1'b1;
                            state    <= StWstb;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                StWstb: begin
                    state <= StIdle;
                end
                StRstb: begin
                    lat_cnt <= LCW'(1);
                    state   <= StRwait;
                end
                StRwait: begin
                    // lat_cnt equals the number of cycles elapsed since the strobe cycle.
                    if (lat_cnt == LAT_LAST) begin
                        resp_sh   <= gb_rdata;
                        out_valid <= 1'b1;
                        byte_cnt  <= '0;
                        state     <= StResp;
                    end else begin
                        lat_cnt <= lat_cnt + LCW'(1);
                    end
                end
                StResp: begin
                    if (out_valid && out_ready) begin
                        if (byte_cnt == D_LAST) begin
                            out_valid <= 1'b0;
                            state     <= StIdle;
                        end else begin
                            resp_sh  <= resp_sh << 8;
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase

`ifdef GB_BRIDGE_TIMEOUT_EN
            if (((state == StAddr) || (state == StData)) && !accept) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt <= '0;
                    state  <= StIdle;
                    if (bad_cmd_cnt != 8'hFF) begin
                        bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
                    end
                end else begin
                    to_cnt <= to_cnt + TCW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_gb_host_bridge.sv
// Self-checking bench for gb_host_bridge: directed scenarios plus randomized traffic
// checked against a word-level memory model of the ghostbus device.
module tb_gb_host_bridge;

    localparam int unsigned GB_AW     = 24;
    localparam int unsigned GB_DW     = 32;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned TO_CYCLES = 1000;
    localparam int unsigned AB        = GB_AW / 8;
    localparam int unsigned DB        = GB_DW / 8;

    logic             gb_clk    = 1'b0;
    logic             rst       = 1'b1;
    logic [7:0]       in_data   = 8'h00;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [GB_AW-1:0] gb_addr;
    logic [GB_DW-1:0] gb_wdata;
    logic [GB_DW-1:0] gb_rdata  = '0;
    logic             gb_wen;
    logic             gb_rstb;
    logic             busy;
    logic [7:0]       bad_cmd_cnt;

    gb_host_bridge #(
        .GB_AW    (GB_AW),
        .GB_DW    (GB_DW),
        .RD_LAT   (RD_LAT),
        .TO_CYCLES(TO_CYCLES)
    ) dut (
        .gb_clk     (gb_clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gb_addr    (gb_addr),
        .gb_wdata   (gb_wdata),
        .gb_rdata   (gb_rdata),
        .gb_wen     (gb_wen),
        .gb_rstb    (gb_rstb),
        .busy       (busy),
        .bad_cmd_cnt(bad_cmd_cnt)
    );

    always #5 gb_clk = ~gb_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ov_cnt = 0;

    always @(posedge gb_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Device contents; unwritten locations return an address-derived pattern.
    logic [GB_DW-1:0] ref_mem [logic [GB_AW-1:0]];

    function automatic logic [GB_DW-1:0] model_rd(input logic [GB_AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return (GB_DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        logic [GB_AW-1:0] a;
        logic [GB_DW-1:0] d;
        int               c;
    } wr_t;

    wr_t              wr_obs [$];
    logic [GB_AW-1:0] rd_obs [$];
    int               rd_cyc [$];
    int               rd_cd       = 0;
    logic [GB_AW-1:0] rd_addr     = '0;
    logic             prev_strobe = 1'b0;

    // Bus monitor and device: read data is valid only in the cycle RD_LAT after the strobe.
    always @(negedge gb_clk) begin
        if (gb_wen || gb_rstb) begin
            check("strobe_excl", gb_wen & gb_rstb, 1'b0);
            check("strobe_in_ready", in_ready, 1'b0);
            check("strobe_single", prev_strobe, 1'b0);
        end
        if (gb_wen) wr_obs.push_back(wr_t'{a: gb_addr, d: gb_wdata, c: cyc});
        if (gb_rstb) begin
            rd_obs.push_back(gb_addr);
            rd_cyc.push_back(cyc);
        end
        if (out_valid) ov_cnt <= ov_cnt + 1;
        prev_strobe <= gb_wen | gb_rstb;
        if (gb_rstb) begin
            rd_cd    <= RD_LAT;
            rd_addr  <= gb_addr;
            gb_rdata <= GB_DW'($urandom);
        end else if (rd_cd > 0) begin
            rd_cd    <= rd_cd - 1;
            gb_rdata <= (rd_cd == 1) ? model_rd(rd_addr) : GB_DW'($urandom);
        end else begin
            gb_rdata <= GB_DW'($urandom);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge gb_clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_gb_addr", gb_addr, '0);
        check("rst_gb_wdata", gb_wdata, '0);
        check("rst_gb_wen", gb_wen, 1'b0);
        check("rst_gb_rstb", gb_rstb, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_bad_cnt", bad_cmd_cnt, 8'h00);
        check("rst_in_ready", in_ready, 1'b1);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state();
        wr_obs.delete();
        rd_obs.delete();
        rd_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("send_stall", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
    endtask

    task automatic do_write(input logic [GB_AW-1:0] a, input logic [GB_DW-1:0] d,
                            input int gapmax);
        int start;
        int ov_base;
        start   = cyc;
        ov_base = ov_cnt;
        send_byte(8'h01, $urandom_range(0, gapmax));
        for (int i = AB - 1; i >= 0; i--) send_byte(a[8*i +: 8], $urandom_range(0, gapmax));
        for (int i = DB - 1; i >= 0; i--) send_byte(d[8*i +: 8], $urandom_range(0, gapmax));
        ref_mem[a] = d;
        wait_idle();
        repeat (2) tick();
        check("wr_count", wr_obs.size(), 1);
        if (wr_obs.size() > 0) begin
            check("wr_addr", wr_obs[0].a, a);
            check("wr_data", wr_obs[0].d, d);
            if (gapmax == 0) check("wr_latency", wr_obs[0].c - start, AB + DB + 1);
        end
        check("wr_no_resp", ov_cnt - ov_base, 0);
        check("wr_no_rstb", rd_obs.size(), 0);
        check("wr_addr_hold", gb_addr, a);
        check("wr_data_hold", gb_wdata, d);
        wr_obs.delete();
    endtask

    task automatic recv(input logic [GB_DW-1:0] exp, input int mode, output int first_cyc);
        int         got;
        int         n;
        int         pi;
        int         pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        logic       stalled;
        logic [7:0] held;
        got       = 0;
        n         = 0;
        pi        = 0;
        stalled   = 1'b0;
        held      = 8'h00;
        first_cyc = -1;
        while (got < DB && n < 500) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = (pat[pi % 7] != 0);
            endcase
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stalled) check("resp_hold", out_data, held);
                check("resp_in_ready", in_ready, 1'b0);
                if (out_ready) begin
                    check("resp_byte", out_data, exp[GB_DW-1-8*got -: 8]);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
                pi++;
            end
            tick();
            n++;
        end
        out_ready = 1'b0;
        if (got < DB) check("resp_timeout", got, DB);
        check("resp_done_valid", out_valid, 1'b0);
        check("resp_done_busy", busy, 1'b0);
        check("resp_done_in_ready", in_ready, 1'b1);
    endtask

    task automatic do_read(input logic [GB_AW-1:0] a, input int gapmax, input int mode);
        int               start;
        int               first;
        logic [GB_DW-1:0] exp;
        start = cyc;
        exp   = model_rd(a);
        send_byte(8'h02, $urandom_range(0, gapmax));
        for (int i = AB - 1; i >= 0; i--) send_byte(a[8*i +: 8], $urandom_range(0, gapmax));
        recv(exp, mode, first);
        check("rd_count", rd_obs.size(), 1);
        if (rd_obs.size() > 0) begin
            check("rd_addr", rd_obs[0], a);
            if (gapmax == 0) check("rd_strobe_lat", rd_cyc[0] - start, AB + 1);
        end
        if (gapmax == 0) check("rd_resp_lat", first - start, AB + 2 + RD_LAT);
        check("rd_no_wen", wr_obs.size(), 0);
        rd_obs.delete();
        rd_cyc.delete();
    endtask

    logic [GB_AW-1:0] pool[4] = '{24'h000010, 24'h000020, 24'hABCDEF, 24'hFFFFFF};

    initial begin
        int               n;
        int               kind;
        int               gm;
        int               bad_exp;
        logic [GB_AW-1:0] a;
        logic [GB_DW-1:0] d;

        tick();
        do_reset();

        // Directed write and reads of 0x000010.
        do_write(24'h000010, 32'hDEADBEEF, 0);
        ref_mem[24'h000010] = 32'h12345678;
        do_read(24'h000010, 0, 0);
        do_read(24'h000010, 0, 2);

        // Bad command bytes followed by a normal read.
        send_byte(8'h7F, 0);
        send_byte(8'h00, 0);
        do_read(24'h000004, 0, 0);
        check("bad_two", bad_cmd_cnt, 8'd2);

        // Reset in the middle of a write packet.
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        do_reset();
        do_read(24'h000020, 0, 0);
        check("rst_mid_no_wen", wr_obs.size(), 0);

        // Reset while a response is pending.
        send_byte(8'h02, 0);
        for (int i = AB - 1; i >= 0; i--) send_byte(8'h00, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("pend_valid", out_valid, 1'b1);
        do_reset();
        repeat (5) tick();
        check("pend_gone", out_valid, 1'b0);

        // Saturation of the bad command counter.
        for (int i = 0; i < 300; i++) begin
            send_byte(8'($urandom_range(3, 255)), 0);
            if (i == 253) check("bad_254", bad_cmd_cnt, 8'd254);
        end
        check("bad_sat", bad_cmd_cnt, 8'd255);

        // Stalled packet: abandoned only when the timeout feature is built in.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        repeat (TO_CYCLES - 1) tick();
        check("to_before_busy", busy, 1'b1);
        tick();
`ifdef GB_BRIDGE_TIMEOUT_EN
        check("to_busy", busy, 1'b0);
        check("to_bad", bad_cmd_cnt, 8'd1);
        check("to_in_ready", in_ready, 1'b1);
`else
        check("to_busy_hold", busy, 1'b1);
        check("to_bad_hold", bad_cmd_cnt, 8'd0);
`endif
        check("to_no_wen", wr_obs.size(), 0);
        check("to_addr_hold", gb_addr, '0);
        check("to_wdata_hold", gb_wdata, '0);

        // Randomized traffic.
        do_reset();
        bad_exp = 0;
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 9);
            gm   = $urandom_range(0, 1) * 2;
            a    = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : GB_AW'($urandom);
            d    = $urandom;
            if (kind == 0) begin
                send_byte(8'($urandom_range(3, 255)), gm);
                if (bad_exp < 255) bad_exp++;
            end else if (kind < 5) begin
                do_write(a, d, gm);
            end else begin
                do_read(a, gm, 1);
            end
        end
        check("rand_bad_cnt", bad_cmd_cnt, bad_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
